// File: rtl/voice_allocator_if.sv
// Note-event handshake between the host PIO bridge and the voice allocator.
// The host side drives events; the allocator answers with ev_ready.
interface voice_allocator_if #(
    parameter int NOTE_W = 7,
    parameter int AMP_W  = 16
);
    logic              ev_valid;
    logic              ev_ready;
    logic              ev_on;
    logic [NOTE_W-1:0] ev_note;
    logic [AMP_W-1:0]  ev_amp;

    modport master (output ev_valid, ev_on, ev_note, ev_amp, input ev_ready);
    modport slave  (input ev_valid, ev_on, ev_note, ev_amp, output ev_ready);
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: retrigger / free / oldest-steal allocation,
// sequencing a shared registered note->increment ROM per note-on.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 7,
    parameter int INC_W      = 24,
    parameter int AMP_W      = 16
) (
    input  logic                        Clk,
    input  logic                        Reset,
    voice_allocator_if.slave            ev,
    output logic [NOTE_W-1:0]           rom_addr,
    input  logic [INC_W-1:0]            rom_data,
    output logic [NUM_VOICES*INC_W-1:0] voice_F,
    output logic [NUM_VOICES*AMP_W-1:0] voice_A,
    output logic [NUM_VOICES-1:0]       voice_key_on,
    output logic [NUM_VOICES-1:0]       voice_load,
    output logic [7:0]                  steal_count
);
    localparam int IDX_W = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {IDLE, SEARCH, LOOKUP, CAPTURE} state_t;
    state_t state_reg, state_next;

    logic              lat_on_reg;
    logic [NOTE_W-1:0] lat_note_reg;
    logic [AMP_W-1:0]  lat_amp_reg;
    logic [IDX_W-1:0]  chosen_reg;
    logic [NOTE_W-1:0] rom_addr_reg;
    logic [7:0]        steal_reg;

    logic [NUM_VOICES-1:0] key_on_reg;
    logic [NUM_VOICES-1:0] load_reg;
    logic [NOTE_W-1:0]     note_reg [NUM_VOICES];
    logic [IDX_W-1:0]      rank_reg [NUM_VOICES];
    logic [INC_W-1:0]      f_reg    [NUM_VOICES];
    logic [AMP_W-1:0]      a_reg    [NUM_VOICES];

    logic [NUM_VOICES-1:0] match_vec, free_vec, oldest_vec;
    logic                  match_any, free_any;
    logic [IDX_W-1:0]      match_idx, free_idx, oldest_idx, pick_idx;
    logic [IDX_W-1:0]      chosen_rank;
    logic                  ready_c;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            assign match_vec[gi]  = key_on_reg[gi] && (note_reg[gi] == lat_note_reg);
            assign free_vec[gi]   = ~key_on_reg[gi];
            assign oldest_vec[gi] = (rank_reg[gi] == IDX_W'(NUM_VOICES - 1));
            assign voice_F[gi*INC_W +: INC_W] = f_reg[gi];
            assign voice_A[gi*AMP_W +: AMP_W] = a_reg[gi];
        end
    endgenerate

    // Lowest index wins within each category, hence the descending scan.
    always_comb begin
        match_any  = |match_vec;
        free_any   = |free_vec;
        match_idx  = '0;
        free_idx   = '0;
        oldest_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (match_vec[i])  match_idx  = IDX_W'(i);
            if (free_vec[i])   free_idx   = IDX_W'(i);
            if (oldest_vec[i]) oldest_idx = IDX_W'(i);
        end
        pick_idx = match_any ? match_idx : (free_any ? free_idx : oldest_idx);
    end

    assign chosen_rank = rank_reg[chosen_reg];

    always_ff @(posedge Clk) begin
        if (Reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (ev.ev_valid) state_next = SEARCH;
            SEARCH:  state_next = lat_on_reg ? LOOKUP : IDLE;
            LOOKUP:  state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_c = (state_reg == IDLE) && !Reset;
    end

    assign ev.ev_ready   = ready_c;
    assign rom_addr      = rom_addr_reg;
    assign steal_count   = steal_reg;
    assign voice_key_on  = key_on_reg;
    assign voice_load    = load_reg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            lat_on_reg   <= 1'b0;
            lat_note_reg <= '0;
            lat_amp_reg  <= '0;
            chosen_reg   <= '0;
            rom_addr_reg <= '0;
            steal_reg    <= '0;
        end else begin
            if (ready_c && ev.ev_valid) begin
                // Zero-amplitude note-on is a release in disguise.
                lat_on_reg   <= ev.ev_on && (ev.ev_amp != '0);
                lat_note_reg <= ev.ev_note;
                lat_amp_reg  <= ev.ev_amp;
            end
            if (state_reg == SEARCH && lat_on_reg) begin
                chosen_reg   <= pick_idx;
                rom_addr_reg <= lat_note_reg;
                if (!match_any && !free_any && steal_reg != 8'hFF)
                    steal_reg <= steal_reg + 8'd1;
            end
        end
    end

    // Note-off keeps F/A/note so the release tail holds pitch.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_on_reg <= '0;
            load_reg   <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_reg[i] <= '0;
                rank_reg[i] <= IDX_W'(i);
                f_reg[i]    <= '0;
                a_reg[i]    <= '0;
            end
        end else begin
            load_reg <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (state_reg == SEARCH && !lat_on_reg && match_vec[i])
                    key_on_reg[i] <= 1'b0;
                if (state_reg == CAPTURE) begin
                    if (chosen_reg == IDX_W'(i)) begin
                        f_reg[i]      <= rom_data;
                        a_reg[i]      <= lat_amp_reg;
                        note_reg[i]   <= lat_note_reg;
                        key_on_reg[i] <= 1'b1;
                        load_reg[i]   <= 1'b1;
                        rank_reg[i]   <= '0;
                    end else if (rank_reg[i] < chosen_rank) begin
                        rank_reg[i] <= rank_reg[i] + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice scheduler between the Nios II note-event PIO and a bank of NCO oscillators. It accepts note-on and note-off events and assigns each note-on to a voice: an already-sounding voice for the same note, else a free voice, else the oldest voice (stealing). It sequences the shared note-to-increment ROM to produce each voice's frequency word, then drives per-voice frequency, amplitude and key_on.

## Interface
- NUM_VOICES, 4, number of NCO voices (2..8)
- NOTE_W, 7, note number width (ROM address width)
- INC_W, 24, frequency increment width (ROM data width)
- AMP_W, 16, amplitude width
- Clk  in  1  system clock (CLOCK_50 domain)
- Reset  in  1  synchronous, active-high
- ev_valid  in  1  event present
- ev_ready  out  1  allocator can accept; high exactly when FSM is IDLE
- ev_on  in  1  1 = note-on, 0 = note-off
- ev_note  in  NOTE_W  note number
- ev_amp  in  AMP_W  note-on amplitude; ignored for note-off
- rom_addr  out  NOTE_W  address to note ROM
- rom_data  in  INC_W  ROM output, registered, valid one cycle after rom_addr is held stable
- voice_F  out  NUM_VOICES*INC_W  per-voice increment, voice i at [i*INC_W +: INC_W]
- voice_A  out  NUM_VOICES*AMP_W  per-voice amplitude
- voice_key_on  out  NUM_VOICES  per-voice gate
- voice_load  out  NUM_VOICES  one-cycle pulse when voice i receives a new F/A
- steal_count  out  8  saturating count of stolen voices

## Operation
- State per voice: key_on, note (NOTE_W), age rank 0..NUM_VOICES-1. Rank 0 is newest. Ranks always form a permutation.
- FSM: IDLE -> SEARCH -> (note-on) LOOKUP -> CAPTURE -> IDLE. A note-off goes SEARCH -> IDLE.
- IDLE: ev_ready=1. On ev_valid, latch ev_on/ev_note/ev_amp and go to SEARCH. A note-on with ev_amp==0 is latched as a note-off.
- SEARCH, note-on, choose the voice by priority:
  - (a) lowest-index voice with key_on=1 and matching note (retrigger);
  - (b) else lowest-index voice with key_on=0;
  - (c) else the voice with rank NUM_VOICES-1 (steal; steal_count += 1, saturating at 255).
  - Register the chosen index and set rom_addr <= note.
- SEARCH, note-off: clear key_on of every active voice whose note matches. No match means no effect. F, A and note stay unchanged so the release tail keeps its pitch.
- LOOKUP: rom_addr held; ROM registers data.
- CAPTURE: for the chosen voice, voice_F <= rom_data, voice_A <= latched amp, key_on <= 1, note <= latched note. Rank update: the chosen voice's rank becomes 0; every voice whose rank was below the chosen voice's old rank increments by 1.
- Ranks change only on note-on.

## Timing
- Event handshake is accepted at edge n (ev_valid & ev_ready). ev_ready is low for cycles n+1 through n+3 for a note-on, and for cycle n+1 only for a note-off.
- Note-on:
  - rom_addr valid from n+2.
  - rom_data is sampled at the end of n+3.
  - voice_F, voice_A and voice_key_on are visible at n+4.
  - voice_load[i] is high only in cycle n+4.
  - ev_ready is high again at n+4.
  - Throughput: one note-on per 4 cycles.
- Note-off: key_on cleared and visible at n+2; ev_ready high at n+2. Throughput: one note-off per 2 cycles.
- Reset values:
  - state IDLE, so ev_ready=1 on the first cycle after Reset falls.
  - voice_F, voice_A, voice_key_on, voice_load, steal_count and rom_addr all 0.
  - note of every voice 0; rank of voice i = i.
- Reset while Reset is high: ev_ready=0 and events are dropped.
- Reset asserted mid-sequence: the in-flight event is discarded, all voices are silenced, and no voice_load pulse is issued.
- rom_addr holds its last value outside LOOKUP.
- ev_* inputs are sampled only on the accept edge; changes afterward have no effect.

## Test plan
- Reset, then note-on note=60 amp=0x4000, with the ROM returning 0x025 8BF -> voice 0 gets F=0x0258BF, A=0x4000, key_on=0001; voice_load=0001 exactly 4 cycles after accept; ranks become 0,1,2,3 → voice0 rank 0, voice1 rank 1.
- Note-ons 60,62,64,67 then note-on 69 -> all four voices occupied, then 69 steals voice 0 (oldest); steal_count=1; voice_key_on=1111.
- Note-on 60 twice -> second retriggers voice 0, voice 1 stays free, steal_count=0, A updates to the second amp.
- Note-on 60, note-off 60 -> key_on=0 two cycles after accept, voice_F unchanged; note-off 61 with nothing held -> no output change, ev_ready back after 2 cycles.
- Note-on with amp=0 for note 60 held -> treated as note-off: key_on cleared, no ROM access, no voice_load.
- Assert Reset in LOOKUP cycle -> no voice_load, all outputs 0, ev_ready=1 the cycle after Reset deasserts; a back-to-back ev_valid held high is accepted every 4 cycles.
